// File: rtl/logic_pod_rle_encoder_pkg.sv
// Shared types for the logic pod run-length encoder.
// Optional timestamp field is compiled in with LOGIC_POD_RLE_TIMESTAMP_EN.
package logic_pod_pkg;

    localparam int unsigned SAMPLE_WIDTH    = 16;
    localparam int unsigned RLE_COUNT_WIDTH = 16;
    localparam logic [RLE_COUNT_WIDTH-1:0] RLE_COUNT_MAX = '1;
`ifdef LOGIC_POD_RLE_TIMESTAMP_EN
    localparam int unsigned RLE_TS_WIDTH    = 32;
`endif

    typedef logic [SAMPLE_WIDTH-1:0] sample_word_t;

    typedef struct packed {
        sample_word_t               word;
        logic [RLE_COUNT_WIDTH-1:0] count;
`ifdef LOGIC_POD_RLE_TIMESTAMP_EN
        logic [RLE_TS_WIDTH-1:0]    ts;
`endif
    } rle_record_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rle_state_t;

endpackage

// File: rtl/logic_pod_rle_encoder_if.sv
// Record stream between the RLE encoder and the capture buffer writer.
// rec_ts exists only with LOGIC_POD_RLE_TIMESTAMP_EN.
interface logic_pod_rle_encoder_if
    import logic_pod_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16
`ifdef LOGIC_POD_RLE_TIMESTAMP_EN
    , parameter int unsigned TS_WIDTH  = 32
`endif
) ();

    logic                   rec_valid;
    logic                   rec_ready;
    sample_word_t           rec_word;
    logic [COUNT_WIDTH-1:0] rec_count;
`ifdef LOGIC_POD_RLE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]    rec_ts;

    modport master (output rec_valid, rec_word, rec_count, rec_ts, input rec_ready);
    modport slave  (input rec_valid, rec_word, rec_count, rec_ts, output rec_ready);
`else
    modport master (output rec_valid, rec_word, rec_count, input rec_ready);
    modport slave  (input rec_valid, rec_word, rec_count, output rec_ready);
`endif

endinterface

// File: rtl/logic_pod_rle_encoder_queue.sv
// Two-entry valid/ready FIFO; a push into a full queue with no pop is dropped
// and reported on drop_o.
module logic_pod_rle_queue #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             drop_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       fill_q, fill_d;
    logic             full;
    logic             pop;
    logic             accept;

    assign full    = (fill_q == 2'd2);
    assign valid_o = (fill_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign pop     = valid_o && ready_i;
    // A pop in the same cycle frees the slot the push lands in.
    assign accept  = push_i && (!full || pop);
    assign drop_o  = push_i && full && !pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ accept;
        fill_d   = fill_q;
        case ({accept, pop})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            fill_q   <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/logic_pod_rle_encoder.sv
// Run-length encoder for the logic pod sample stream, feeding a 2-entry record queue.
// Define LOGIC_POD_RLE_TIMESTAMP_EN to attach a first-sample timestamp to each record.
module logic_pod_rle_encoder
    import logic_pod_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = $bits(RLE_COUNT_MAX)
`ifdef LOGIC_POD_RLE_TIMESTAMP_EN
    , parameter int unsigned TS_WIDTH  = 32
`endif
) (
    input  logic                    clk_312p5mhz,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [7:0]              p_in,
    input  logic [7:0]              n_in,
    logic_pod_rle_encoder_if.master rec,
    output logic                    overflow,
    output logic                    busy
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef struct packed {
        sample_word_t           word;
        logic [COUNT_WIDTH-1:0] count;
`ifdef LOGIC_POD_RLE_TIMESTAMP_EN
        logic [TS_WIDTH-1:0]    ts;
`endif
    } rec_t;

    rle_state_t             state_q, state_d;
    sample_word_t           cur_word_q;
    logic                   en_q;
    sample_word_t           prev_q, prev_d;
    logic [COUNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   push;
    logic                   run_start;
    logic                   drop;
    logic                   q_valid;
    rec_t                   push_rec;
    rec_t                   q_head;

`ifdef LOGIC_POD_RLE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]    ts_q;
    logic [TS_WIDTH-1:0]    run_ts_q;

    always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            run_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (run_start) begin
                run_ts_q <= ts_q;
            end
        end
    end

    assign push_rec = '{word: prev_q, count: run_cnt_q, ts: run_ts_q};
    assign rec.rec_ts = q_head.ts;
`else
    assign push_rec = '{word: prev_q, count: run_cnt_q};
`endif

    // en is registered with the sample so the FSM sees them aligned.
    always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
        if (!rst_n) begin
            cur_word_q <= '0;
            en_q       <= 1'b0;
            state_q    <= IDLE;
            prev_q     <= '0;
            run_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            cur_word_q <= {n_in, p_in};
            en_q       <= en;
            state_q    <= state_d;
            prev_q     <= prev_d;
            run_cnt_q  <= run_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        run_cnt_d = run_cnt_q;
        push      = 1'b0;
        run_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_q) begin
                    run_start = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (!en_q) begin
                    state_d = FLUSH;
                end else if (cur_word_q != prev_q || run_cnt_q == CNT_MAX) begin
                    // A saturated run closes and reopens on the same word.
                    push      = 1'b1;
                    run_start = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (run_start) begin
            prev_d    = cur_word_q;
            run_cnt_d = COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (state_q == IDLE && en_q) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end
    end

    logic_pod_rle_queue #(
        .WIDTH($bits(rec_t))
    ) u_queue (
        .clk_i       (clk_312p5mhz),
        .rst_ni      (rst_n),
        .push_i      (push),
        .push_data_i (push_rec),
        .drop_o      (drop),
        .valid_o     (q_valid),
        .ready_i     (rec.rec_ready),
        .data_o      (q_head)
    );

    assign rec.rec_valid = q_valid;
    assign rec.rec_word  = q_head.word;
    assign rec.rec_count = q_head.count;
    assign overflow      = overflow_q;
    assign busy          = (state_q != IDLE) || q_valid;

endmodule

// File: tb/tb_logic_pod_rle_encoder.sv
// Directed bench for logic_pod_rle_encoder: a default-width instance and a
// COUNT_WIDTH=4 instance for run saturation.
`timescale 1ns/1ps
module tb_logic_pod_rle_encoder;
    import logic_pod_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, en4;
    logic [7:0] p_in, n_in;
    logic       ovf, ovf4, busy, busy4;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    logic_pod_rle_encoder_if #(.COUNT_WIDTH(16)) rif ();
    logic_pod_rle_encoder_if #(.COUNT_WIDTH(4))  rif4 ();

    logic_pod_rle_encoder #(.COUNT_WIDTH(16)) dut (
        .clk_312p5mhz (clk),
        .rst_n        (rst_n),
        .en           (en),
        .p_in         (p_in),
        .n_in         (n_in),
        .rec          (rif),
        .overflow     (ovf),
        .busy         (busy)
    );

    logic_pod_rle_encoder #(.COUNT_WIDTH(4)) dut4 (
        .clk_312p5mhz (clk),
        .rst_n        (rst_n),
        .en           (en4),
        .p_in         (p_in),
        .n_in         (n_in),
        .rec          (rif4),
        .overflow     (ovf4),
        .busy         (busy4)
    );

    typedef struct {
        logic [15:0] w;
        logic [15:0] c;
        logic [31:0] ts;
    } rec_s;

    rec_s got[$];
    rec_s got4[$];

    // Every accepted record is captured at the negedge before its pop edge.
    always @(negedge clk) begin
        rec_s r;
        r.w  = rif.rec_word;
        r.c  = rif.rec_count;
        r.ts = '0;
`ifdef LOGIC_POD_RLE_TIMESTAMP_EN
        r.ts = rif.rec_ts;
`endif
        if (rif.rec_valid && rif.rec_ready) got.push_back(r);
    end

    always @(negedge clk) begin
        rec_s r;
        r.w  = rif4.rec_word;
        r.c  = 16'(rif4.rec_count);
        r.ts = '0;
        if (rif4.rec_valid && rif4.rec_ready) got4.push_back(r);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [15:0] w);
        p_in = w[7:0];
        n_in = w[15:8];
    endtask

    task automatic wait_idle(input bit use4, input string name);
        int unsigned n = 0;
        step();
        while ((use4 ? busy4 : busy) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (use4 ? busy4 : busy) begin
            errors++;
            $display("FAIL %s_idle_timeout busy=1 required 0", name);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        en4 = 1'b0;
        rif.rec_ready = 1'b0;
        rif4.rec_ready = 1'b0;
        set_word(16'h0000);
        repeat (3) step();
        checks += 5;
        if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rif.rec_valid); end
        if (rif.rec_word !== 16'h0) begin errors++; $display("FAIL reset_word got %h exp 0000", rif.rec_word); end
        if (rif.rec_count !== 16'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", rif.rec_count); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", ovf); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_constant_run();
        got.delete();
        rif.rec_ready = 1'b1;
        set_word(16'hA55A);
        en = 1'b1;
        repeat (10) step();
        en = 1'b0;
        wait_idle(1'b0, "constant");
        checks += 4;
        if (got.size() != 1) begin errors++; $display("FAIL constant_nrec got %0d exp 1", got.size()); end
        if (got.size() > 0 && got[0].w !== 16'hA55A) begin errors++; $display("FAIL constant_word got %h exp a55a", got[0].w); end
        if (got.size() > 0 && got[0].c !== 16'd10) begin errors++; $display("FAIL constant_count got %0d exp 10", got[0].c); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL constant_overflow got %b exp 0", ovf); end
    endtask

    task automatic test_alternating();
        logic [15:0] exp_w [4] = '{16'h0001, 16'h0002, 16'h0001, 16'h0002};
        got.delete();
        rif.rec_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_word(exp_w[i]);
            step();
        end
        en = 1'b0;
        wait_idle(1'b0, "alternating");
        checks += 2;
        if (got.size() != 4) begin errors++; $display("FAIL alt_nrec got %0d exp 4", got.size()); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL alt_overflow got %b exp 0", ovf); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                checks += 2;
                if (got[i].w !== exp_w[i]) begin errors++; $display("FAIL alt_word%0d got %h exp %h", i, got[i].w, exp_w[i]); end
                if (got[i].c !== 16'd1) begin errors++; $display("FAIL alt_count%0d got %0d exp 1", i, got[i].c); end
            end
        end
    endtask

    task automatic test_saturation();
        got4.delete();
        rif4.rec_ready = 1'b1;
        set_word(16'h00FF);
        en4 = 1'b1;
        repeat (20) step();
        en4 = 1'b0;
        wait_idle(1'b1, "saturation");
        checks += 5;
        if (got4.size() != 2) begin errors++; $display("FAIL sat_nrec got %0d exp 2", got4.size()); end
        if (got4.size() > 0 && got4[0].w !== 16'h00FF) begin errors++; $display("FAIL sat_word0 got %h exp 00ff", got4[0].w); end
        if (got4.size() > 0 && got4[0].c !== 16'd15) begin errors++; $display("FAIL sat_count0 got %0d exp 15", got4[0].c); end
        if (got4.size() > 1 && got4[1].w !== 16'h00FF) begin errors++; $display("FAIL sat_word1 got %h exp 00ff", got4[1].w); end
        if (got4.size() > 1 && got4[1].c !== 16'd5) begin errors++; $display("FAIL sat_count1 got %0d exp 5", got4[1].c); end
    endtask

    task automatic test_overflow();
        logic [15:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        got.delete();
        rif.rec_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_word(words[i]);
            step();
        end
        en = 1'b0;
        repeat (4) step();
        checks += 5;
        if (rif.rec_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b exp 1", rif.rec_valid); end
        if (rif.rec_word !== 16'h1111) begin errors++; $display("FAIL ovf_head_word got %h exp 1111", rif.rec_word); end
        if (rif.rec_count !== 16'd1) begin errors++; $display("FAIL ovf_head_count got %0d exp 1", rif.rec_count); end
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
        if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b exp 1", busy); end
        rif.rec_ready = 1'b1;
        wait_idle(1'b0, "overflow");
        checks += 4;
        if (got.size() != 2) begin errors++; $display("FAIL ovf_nrec got %0d exp 2", got.size()); end
        if (got.size() > 0 && got[0].w !== 16'h1111) begin errors++; $display("FAIL ovf_word0 got %h exp 1111", got[0].w); end
        if (got.size() > 1 && got[1].w !== 16'h2222) begin errors++; $display("FAIL ovf_word1 got %h exp 2222", got[1].w); end
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    endtask

    task automatic test_reset_midrun();
        got.delete();
        rif.rec_ready = 1'b0;
        en = 1'b1;
        set_word(16'h0005);
        step();
        set_word(16'h0006);
        step();
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf_cleared_on_start got %b exp 0", ovf); end
        set_word(16'h0007);
        step();
        set_word(16'h0008);
        step();
        step();
        step();
        checks += 2;
        if (ovf !== 1'b1) begin errors++; $display("FAIL rst_pre_overflow got %b exp 1", ovf); end
        if (rif.rec_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b exp 1", rif.rec_valid); end
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        checks += 3;
        if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rif.rec_valid); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", ovf); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        rif.rec_ready = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        checks += 2;
        if (got.size() != 0) begin errors++; $display("FAIL rst_stale_records got %0d exp 0", got.size()); end
        if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL rst_post_valid got %b exp 0", rif.rec_valid); end
    endtask

    task automatic test_back_to_back();
        logic en_pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        got.delete();
        rif.rec_ready = 1'b1;
        set_word(16'hBEEF);
        for (int i = 0; i < 8; i++) begin
            en = en_pat[i];
            step();
        end
        en = 1'b0;
        wait_idle(1'b0, "back_to_back");
        checks += 5;
        if (got.size() != 2) begin errors++; $display("FAIL b2b_nrec got %0d exp 2", got.size()); end
        if (got.size() > 0 && got[0].w !== 16'hBEEF) begin errors++; $display("FAIL b2b_word0 got %h exp beef", got[0].w); end
        if (got.size() > 0 && got[0].c !== 16'd3) begin errors++; $display("FAIL b2b_count0 got %0d exp 3", got[0].c); end
        if (got.size() > 1 && got[1].w !== 16'hBEEF) begin errors++; $display("FAIL b2b_word1 got %h exp beef", got[1].w); end
        if (got.size() > 1 && got[1].c !== 16'd2) begin errors++; $display("FAIL b2b_count1 got %0d exp 2", got[1].c); end
    endtask

`ifdef LOGIC_POD_RLE_TIMESTAMP_EN
    task automatic test_timestamp();
        got.delete();
        rif.rec_ready = 1'b1;
        en = 1'b1;
        set_word(16'h0A0A);
        repeat (7) step();
        set_word(16'h0B0B);
        repeat (3) step();
        en = 1'b0;
        wait_idle(1'b0, "timestamp");
        checks += 4;
        if (got.size() != 2) begin errors++; $display("FAIL ts_nrec got %0d exp 2", got.size()); end
        if (got.size() > 0 && got[0].c !== 16'd7) begin errors++; $display("FAIL ts_count0 got %0d exp 7", got[0].c); end
        if (got.size() > 1 && got[1].c !== 16'd3) begin errors++; $display("FAIL ts_count1 got %0d exp 3", got[1].c); end
        if (got.size() > 1 && (got[1].ts - got[0].ts) !== 32'd7) begin
            errors++;
            $display("FAIL ts_delta got %0d exp 7", got[1].ts - got[0].ts);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_constant_run();
        test_alternating();
        test_saturation();
        test_overflow();
        test_reset_midrun();
        test_back_to_back();
`ifdef LOGIC_POD_RLE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
